// File: rtl/bsg_wormhole_packet_arbiter_pkg.sv
// Shared types and helpers for the wormhole packet arbiter.
// Optional output register slice: define BSG_WORMHOLE_PACKET_ARB_OUT_REG_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

// Header layout, LSB first: x_cord, y_cord, len.
`ifndef BSG_WORMHOLE_PKT_ARB_HEADER_T
`define BSG_WORMHOLE_PKT_ARB_HEADER_T(name, xw, yw, lw) \
  typedef struct packed { \
    logic [(lw)-1:0] len; \
    logic [(yw)-1:0] y_cord; \
    logic [(xw)-1:0] x_cord; \
  } name;
`endif

package bsg_wormhole_packet_arbiter_pkg;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eBusy = 1'b1
  } state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bsg_wormhole_packet_arb_rr.sv
// Combinational round-robin search: first valid source at or after rr_ptr_i.
module bsg_wormhole_packet_arb_rr #(
  parameter int num_in_p = 4
) (
  input  logic [num_in_p-1:0]                     v_i,
  input  logic [`BSG_SAFE_CLOG2(num_in_p)-1:0]    rr_ptr_i,
  output logic [num_in_p-1:0]                     grant_o,
  output logic [`BSG_SAFE_CLOG2(num_in_p)-1:0]    idx_o,
  output logic                                    v_o
);

  localparam int ptr_width_lp = `BSG_SAFE_CLOG2(num_in_p);

  logic [ptr_width_lp-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    v_o     = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      cand = ptr_width_lp'((32'(rr_ptr_i) + i) % 32'(num_in_p));
      if (!v_o && v_i[cand]) begin
        v_o           = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/bsg_wormhole_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one wormhole flit link.
// Optional registered skid output: define BSG_WORMHOLE_PACKET_ARB_OUT_REG_EN.
module bsg_wormhole_packet_arbiter
  import bsg_wormhole_packet_arbiter_pkg::*;
#(
  parameter int num_in_p       = 4,
  parameter int flit_width_p   = 8,
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 2,
  parameter int max_num_flit_p = 3
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_in_p*flit_width_p-1:0] data_i,
  input  logic [num_in_p-1:0]              v_i,
  output logic [num_in_p-1:0]              ready_o,
  output logic [flit_width_p-1:0]          data_o,
  output logic                             v_o,
  input  logic                             ready_i,
  output logic [num_in_p-1:0]              grant_o
);

  localparam int len_width_lp = `BSG_SAFE_CLOG2(max_num_flit_p);
  localparam int ptr_width_lp = `BSG_SAFE_CLOG2(num_in_p);

  `BSG_WORMHOLE_PKT_ARB_HEADER_T(hdr_s, x_cord_width_p, y_cord_width_p, len_width_lp)

  localparam int len_lsb_lp = $bits(hdr_s) - len_width_lp;
  localparam logic [num_in_p-1:0] one_lp = num_in_p'(1);

  state_e                  state_q, state_d;
  logic [len_width_lp-1:0] cnt_q, cnt_d;
  logic [ptr_width_lp-1:0] owner_q, owner_d;
  logic [ptr_width_lp-1:0] rr_ptr_q, rr_ptr_d;

  logic [num_in_p-1:0]     rr_grant, arb_grant, arb_ready_vec;
  logic [ptr_width_lp-1:0] rr_idx, sel_idx;
  logic                    rr_v, arb_v, arb_ready, arb_hs;
  logic [flit_width_p-1:0] arb_data, out_data;
  logic [len_width_lp-1:0] hdr_len;
  logic                    out_v;

  bsg_wormhole_packet_arb_rr #(.num_in_p(num_in_p)) rr (
    .v_i     (v_i),
    .rr_ptr_i(rr_ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .v_o     (rr_v)
  );

  always_comb begin
    sel_idx       = (state_q == eBusy) ? owner_q : rr_idx;
    arb_v         = (state_q == eBusy) ? v_i[owner_q] : rr_v;
    arb_grant     = (state_q == eBusy) ? (one_lp << owner_q) : rr_grant;
    arb_ready_vec = arb_grant & {num_in_p{arb_ready}};
    arb_data      = data_i[sel_idx*flit_width_p +: flit_width_p];
    hdr_len       = arb_data[len_lsb_lp +: len_width_lp];
    arb_hs        = arb_v & arb_ready;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (arb_hs) begin
      if (state_q == eIdle) begin
        if (hdr_len == '0) begin
          rr_ptr_d = ptr_width_lp'(rr_next(32'(rr_idx), num_in_p));
        end else begin
          cnt_d   = hdr_len;
          owner_d = rr_idx;
          state_d = eBusy;
        end
      end else begin
        cnt_d = cnt_q - len_width_lp'(1);
        if (cnt_q == len_width_lp'(1)) begin
          state_d  = eIdle;
          rr_ptr_d = ptr_width_lp'(rr_next(32'(owner_q), num_in_p));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      cnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef BSG_WORMHOLE_PACKET_ARB_OUT_REG_EN
  // Two-entry skid: the arbiter sees ready as long as the skid slot is empty.
  logic                    out_v_q, skid_v_q;
  logic [flit_width_p-1:0] out_data_q, skid_data_q;

  assign arb_ready = ~skid_v_q;
  assign out_v     = out_v_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_q     <= 1'b0;
      skid_v_q    <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else if (!out_v_q || ready_i) begin
      if (skid_v_q) begin
        out_v_q    <= 1'b1;
        out_data_q <= skid_data_q;
        skid_v_q   <= 1'b0;
      end else begin
        out_v_q    <= arb_v;
        out_data_q <= arb_data;
      end
    end else if (arb_hs) begin
      skid_v_q    <= 1'b1;
      skid_data_q <= arb_data;
    end
  end
`else
  assign arb_ready = ready_i;
  assign out_v     = arb_v;
  assign out_data  = arb_data;
`endif

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign v_o     = reset_n_i & out_v;
  assign data_o  = out_data;
  assign grant_o = {num_in_p{reset_n_i}} & arb_grant;
  assign ready_o = {num_in_p{reset_n_i}} & arb_ready_vec;

  a_len_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == eIdle && arb_hs) |-> (32'(hdr_len) < 32'(max_num_flit_p)));

endmodule

// File: tb/tb_bsg_wormhole_packet_arbiter.sv
// Directed self-checking bench for bsg_wormhole_packet_arbiter (4 sources, 8-bit flits).
module tb_bsg_wormhole_packet_arbiter;

  localparam int N  = 4;
  localparam int FW = 8;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [N*FW-1:0]   data_i;
  logic [N-1:0]      v_i;
  logic [N-1:0]      ready_o;
  logic [FW-1:0]     data_o;
  logic              v_o;
  logic              ready_i;
  logic [N-1:0]      grant_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_wormhole_packet_arbiter #(
    .num_in_p      (N),
    .flit_width_p  (FW),
    .x_cord_width_p(2),
    .y_cord_width_p(2),
    .max_num_flit_p(3)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (data_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .v_o      (v_o),
    .ready_i  (ready_i),
    .grant_o  (grant_o)
  );

  function automatic logic [7:0] hdr(input logic [1:0] x, input logic [1:0] y,
                                     input logic [1:0] len, input logic [1:0] pl);
    return {pl, len, y, x};
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_src(input logic [1:0] i, input logic v, input logic [7:0] d);
    v_i[i] = v;
    data_i[i*FW +: FW] = d;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b1; v_i = '0; data_i = '0; ready_i = 1'b1;
    #1 reset_n_i = 1'b0;
    #2;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
    checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", ready_o); end
    for (int i = 0; i < N; i++) set_src(2'(i), 1'b1, hdr(2'(i), 2'(i), 2'd0, 2'd0));
    #2;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_held_v_o: got %b want 0", v_o); end
    checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL reset_held_ready: got %b want 0000", ready_o); end
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_held_grant: got %b want 0000", grant_o); end
    cycle();
    reset_n_i = 1'b1;
    v_i = '0;
    #2;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL idle_v_o: got %b want 0", v_o); end
    checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL idle_grant: got %b want 0000", grant_o); end
    checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", ready_o); end
    cycle();
  endtask

`ifndef BSG_WORMHOLE_PACKET_ARB_OUT_REG_EN
  task automatic test_rotation();
    logic [7:0] exp_d;
    logic [3:0] exp_g;
    for (int i = 0; i < N; i++) set_src(2'(i), 1'b1, hdr(2'(i), 2'(3 - i), 2'd0, 2'(i)));
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = hdr(2'(k % 4), 2'(3 - (k % 4)), 2'd0, 2'(k % 4));
      #2;
      checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL rot_grant[%0d]: got %b want %b", k, grant_o, exp_g); end
      checks++; if (data_o !== exp_d) begin errors++; $display("FAIL rot_data[%0d]: got %h want %h", k, data_o, exp_d); end
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL rot_v[%0d]: got %b want 1", k, v_o); end
      checks++; if (ready_o !== exp_g) begin errors++; $display("FAIL rot_ready[%0d]: got %b want %b", k, ready_o, exp_g); end
      cycle();
    end
    v_i = '0;
  endtask

  task automatic test_wormhole_lock();
    logic [7:0] f [3];
    f[0] = hdr(2'd1, 2'd1, 2'd2, 2'd1); f[1] = 8'hA5; f[2] = 8'h5A;
    set_src(2'd0, 1'b1, hdr(2'd0, 2'd0, 2'd0, 2'd3));
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_src(2'd1, 1'b1, f[k]);
      #2;
      checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL lock_grant[%0d]: got %b want 0010", k, grant_o); end
      checks++; if (data_o !== f[k]) begin errors++; $display("FAIL lock_data[%0d]: got %h want %h", k, data_o, f[k]); end
      checks++; if (ready_o !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d]: got %b want 0010", k, ready_o); end
      cycle();
    end
    set_src(2'd1, 1'b0, 8'h00);
    #2;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL lock_next_grant: got %b want 0001", grant_o); end
    checks++; if (data_o !== hdr(2'd0, 2'd0, 2'd0, 2'd3)) begin errors++; $display("FAIL lock_next_data: got %h want %h", data_o, hdr(2'd0, 2'd0, 2'd0, 2'd3)); end
    cycle();
    v_i = '0;
  endtask

  task automatic test_owner_stall();
    set_src(2'd0, 1'b1, hdr(2'd0, 2'd0, 2'd0, 2'd0));
    set_src(2'd2, 1'b1, hdr(2'd2, 2'd2, 2'd2, 2'd2));
    ready_i = 1'b1;
    #2;
    checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL stall_hdr_grant: got %b want 0100", grant_o); end
    cycle();
    set_src(2'd2, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL stall_v[%0d]: got %b want 0", k, v_o); end
      checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL stall_grant[%0d]: got %b want 0100", k, grant_o); end
      checks++; if ((ready_o & 4'b1011) !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want x0xx zero", k, ready_o); end
      cycle();
    end
    set_src(2'd2, 1'b1, 8'h3C);
    #2;
    checks++; if (v_o !== 1'b1 || data_o !== 8'h3C) begin errors++; $display("FAIL stall_body1: got v=%b d=%h want v=1 d=3c", v_o, data_o); end
    cycle();
    set_src(2'd2, 1'b1, 8'hC3);
    #2;
    checks++; if (v_o !== 1'b1 || data_o !== 8'hC3 || grant_o !== 4'b0100) begin errors++; $display("FAIL stall_tail: got v=%b d=%h g=%b want v=1 d=c3 g=0100", v_o, data_o, grant_o); end
    cycle();
    set_src(2'd2, 1'b0, 8'h00);
    #2;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL stall_next_grant: got %b want 0001", grant_o); end
    cycle();
    v_i = '0;
  endtask

  task automatic test_backpressure();
    logic [7:0] f [3];
    f[0] = hdr(2'd3, 2'd1, 2'd2, 2'd1); f[1] = 8'h96; f[2] = 8'h69;
    for (int c = 0; c < 6; c++) begin
      ready_i = 1'(c % 2);
      set_src(2'd3, 1'b1, f[c/2]);
      #2;
      checks++; if (v_o !== 1'b1 || data_o !== f[c/2]) begin errors++; $display("FAIL bp_flit[%0d]: got v=%b d=%h want v=1 d=%h", c, v_o, data_o, f[c/2]); end
      checks++; if (ready_o !== {ready_i, 3'b000}) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", c, ready_o, {ready_i, 3'b000}); end
      checks++; if (grant_o !== 4'b1000) begin errors++; $display("FAIL bp_grant[%0d]: got %b want 1000", c, grant_o); end
      cycle();
    end
    set_src(2'd3, 1'b0, 8'h00);
    ready_i = 1'b1;
    #2;
    checks++; if (v_o !== 1'b0 || grant_o !== 4'b0000) begin errors++; $display("FAIL bp_done: got v=%b g=%b want v=0 g=0000", v_o, grant_o); end
    cycle();
  endtask
`endif

  task automatic test_async_reset();
    ready_i = 1'b1;
    set_src(2'd0, 1'b1, hdr(2'd0, 2'd0, 2'd2, 2'd0));
    #2;
    checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL ar_hdr_grant: got %b want 0001", grant_o); end
    cycle();
    set_src(2'd0, 1'b1, 8'hF0);
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL ar_v_o: got %b want 0", v_o); end
    checks++; if (grant_o !== 4'b0000 || ready_o !== 4'b0000) begin errors++; $display("FAIL ar_quiet: got g=%b r=%b want 0000", grant_o, ready_o); end
    cycle();
    reset_n_i = 1'b1;
    ready_i = 1'b0;
    v_i = '0;
    set_src(2'd1, 1'b1, hdr(2'd1, 2'd0, 2'd0, 2'd1));
    #2;
    checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL ar_lock_cleared: got %b want 0010", grant_o); end
    reset_n_i = 1'b0;
    v_i = '0;
    cycle();
    reset_n_i = 1'b1;
    ready_i = 1'b1;
    cycle();
  endtask

  task automatic test_random_ready();
    logic [7:0] q0 [$];
    logic [7:0] q2 [$];
    logic [7:0] exp [3];
    logic [7:0] pd;
    logic [3:0] fire;
    logic       pv;
    int         n;
    exp[0] = hdr(2'd0, 2'd1, 2'd0, 2'd2);
    exp[1] = hdr(2'd2, 2'd0, 2'd1, 2'd3);
    exp[2] = 8'hE7;
    q0.push_back(exp[0]);
    q2.push_back(exp[1]);
    q2.push_back(exp[2]);
    n = 0; pv = 1'b0; pd = '0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      set_src(2'd0, q0.size() != 0, (q0.size() != 0) ? q0[0] : 8'h00);
      set_src(2'd2, q2.size() != 0, (q2.size() != 0) ? q2[0] : 8'h00);
      ready_i = 1'($urandom_range(0, 1));
      #2;
      if (c == 0) begin
`ifdef BSG_WORMHOLE_PACKET_ARB_OUT_REG_EN
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rr_latency: got v=%b want 0", v_o); end
`else
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL rr_latency: got v=%b want 1", v_o); end
`endif
      end
      if (pv) begin
        checks++; if (v_o !== 1'b1 || data_o !== pd) begin errors++; $display("FAIL rr_hold[%0d]: got v=%b d=%h want v=1 d=%h", c, v_o, data_o, pd); end
      end
      if (v_o && ready_i) begin
        checks++; if (data_o !== exp[n]) begin errors++; $display("FAIL rr_seq[%0d]: got %h want %h", n, data_o, exp[n]); end
        n++;
      end
      pv   = v_o && !ready_i;
      pd   = data_o;
      fire = ready_o & v_i;
      cycle();
      if (fire[0]) void'(q0.pop_front());
      if (fire[2]) void'(q2.pop_front());
    end
    checks++; if (n != 3) begin errors++; $display("FAIL rr_count: got %0d flits want 3", n); end
    v_i = '0;
    ready_i = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
`ifndef BSG_WORMHOLE_PACKET_ARB_OUT_REG_EN
    test_rotation();
    test_wormhole_lock();
    test_owner_stall();
    test_backpressure();
`endif
    test_async_reset();
    test_random_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
